// File: rtl/sdram_responder.sv
// SDR SDRAM device responder: the memory end of the sdram_wire interface.
// Decodes SDR commands, tracks open rows per bank, and stores data in an
// internal array. Read data returns on dq after the programmed CAS latency.
// The first protocol violation is captured in err/err_code and held until reset.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_WAIT_PRE  | after reset, waiting for PRECHARGE with A10=1
//   S_WAIT_REF  | counting down the required init auto-refreshes
//   S_WAIT_MRS  | refreshes done, waiting for a legal mode register set
//   S_READY     | init complete, normal command decode
module sdram_responder #(
    parameter int ROW_BITS       = 4,
    parameter int COL_BITS       = 4,
    parameter int INIT_REFRESHES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [12:0] sdram_wire_addr,
    input  logic [1:0]  sdram_wire_ba,
    input  logic        sdram_wire_cs_n,
    input  logic        sdram_wire_ras_n,
    input  logic        sdram_wire_cas_n,
    input  logic        sdram_wire_we_n,
    input  logic        sdram_wire_cke,
    input  logic [1:0]  sdram_wire_dqm,
    inout  wire  [15:0] sdram_wire_dq,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int RCW   = $clog2(INIT_REFRESHES + 2);

    localparam logic [2:0] C_NOP   = 3'b111;
    localparam logic [2:0] C_ACT   = 3'b011;
    localparam logic [2:0] C_READ  = 3'b101;
    localparam logic [2:0] C_WRITE = 3'b100;
    localparam logic [2:0] C_PRE   = 3'b010;
    localparam logic [2:0] C_REF   = 3'b001;
    localparam logic [2:0] C_MRS   = 3'b000;

    localparam logic [2:0] E_BEFORE_INIT = 3'd1;
    localparam logic [2:0] E_MODE        = 3'd2;
    localparam logic [2:0] E_ACT_ACTIVE  = 3'd3;
    localparam logic [2:0] E_BANK_IDLE   = 3'd4;
    localparam logic [2:0] E_BUS_CONFL   = 3'd5;
    localparam logic [2:0] E_REF_ACTIVE  = 3'd6;

    typedef enum logic [1:0] {
        S_WAIT_PRE,
        S_WAIT_REF,
        S_WAIT_MRS,
        S_READY
    } state_t;

    state_t                state, state_next;
    logic [RCW-1:0]        ref_left;
    logic                  cl_3;
    logic [3:0]            bank_active;
    logic [ROW_BITS-1:0]   bank_row [4];
    logic [15:0]           mem [DEPTH];

    // read pipe: p1 -> p0 -> out; out drives dq
    logic                  p1_valid, p0_valid, out_valid;
    logic [15:0]           p1_data, p0_data, out_data;
    logic [1:0]            p1_mask, p0_mask, out_mask;

    logic                  cmd_valid;
    logic [2:0]            cmd;
    logic                  mode_legal;
    logic                  any_active;
    logic                  rd_inflight;
    logic [AW-1:0]         idx;
    logic [15:0]           rd_word;

    logic                  ref_load, ref_dec, mode_load, act_en;
    logic                  rd_en, wr_en, pre_all, pre_bank, close_rw;
    logic [2:0]            err_now;

    logic                  unused_addr;

    assign unused_addr = ^sdram_wire_addr;

    assign cmd_valid   = sdram_wire_cke && !sdram_wire_cs_n && !reset_reset;
    assign cmd         = {sdram_wire_ras_n, sdram_wire_cas_n, sdram_wire_we_n};
    assign mode_legal  = ((sdram_wire_addr[6:4] == 3'd2) || (sdram_wire_addr[6:4] == 3'd3))
                         && (sdram_wire_addr[2:0] == 3'd0);
    assign any_active  = |bank_active;
    assign rd_inflight = out_valid || p0_valid || p1_valid;
    assign idx         = {sdram_wire_ba, bank_row[sdram_wire_ba], sdram_wire_addr[COL_BITS-1:0]};
    assign rd_word     = mem[idx];
    assign init_done   = (state == S_READY);

    assign sdram_wire_dq[7:0]  = (out_valid && !out_mask[0]) ? out_data[7:0]  : 8'bz;
    assign sdram_wire_dq[15:8] = (out_valid && !out_mask[1]) ? out_data[15:8] : 8'bz;

    // init sequencing state and refresh down-counter
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state    <= S_WAIT_PRE;
            ref_left <= '0;
        end else begin
            state <= state_next;
            if (ref_load)
                ref_left <= RCW'(INIT_REFRESHES);
            else if (ref_dec)
                ref_left <= ref_left - RCW'(1);
        end
    end

    // command decode: next state, per-command actions and the single error code
    always_comb begin
        state_next = state;
        ref_load   = 1'b0;
        ref_dec    = 1'b0;
        mode_load  = 1'b0;
        act_en     = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        pre_all    = 1'b0;
        pre_bank   = 1'b0;
        close_rw   = 1'b0;
        err_now    = 3'd0;
        if (cmd_valid && (cmd != C_NOP)) begin
            unique case (state)
                S_WAIT_PRE: begin
                    if ((cmd == C_PRE) && sdram_wire_addr[10]) begin
                        pre_all    = 1'b1;
                        ref_load   = 1'b1;
                        state_next = (INIT_REFRESHES == 0) ? S_WAIT_MRS : S_WAIT_REF;
                    end else begin
                        err_now = E_BEFORE_INIT;
                    end
                end
                S_WAIT_REF: begin
                    if (cmd == C_REF) begin
                        ref_dec = 1'b1;
                        if (ref_left == RCW'(1))
                            state_next = S_WAIT_MRS;
                    end else begin
                        err_now = E_BEFORE_INIT;
                    end
                end
                S_WAIT_MRS: begin
                    if (cmd != C_MRS) begin
                        err_now = E_BEFORE_INIT;
                    end else if (!mode_legal) begin
                        err_now = E_MODE;
                    end else begin
                        mode_load  = 1'b1;
                        state_next = S_READY;
                    end
                end
                S_READY: begin
                    case (cmd)
                        C_ACT: begin
                            if (bank_active[sdram_wire_ba])
                                err_now = E_ACT_ACTIVE;
                            else
                                act_en = 1'b1;
                        end
                        C_READ, C_WRITE: begin
                            if (!bank_active[sdram_wire_ba]) begin
                                err_now = E_BANK_IDLE;
                            end else begin
                                close_rw = sdram_wire_addr[10];
                                if (cmd == C_READ) begin
                                    rd_en = 1'b1;
                                end else begin
                                    wr_en = 1'b1;
                                    if (rd_inflight)
                                        err_now = E_BUS_CONFL;
                                end
                            end
                        end
                        C_PRE: begin
                            if (sdram_wire_addr[10])
                                pre_all = 1'b1;
                            else
                                pre_bank = 1'b1;
                        end
                        C_REF: begin
                            if (any_active)
                                err_now = E_REF_ACTIVE;
                        end
                        C_MRS: begin
                            if (any_active || !mode_legal)
                                err_now = E_MODE;
                            else
                                mode_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // CAS latency register; only 2 or 3 can ever be loaded
    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            cl_3 <= 1'b0;
        else if (mode_load)
            cl_3 <= (sdram_wire_addr[6:4] == 3'd3);
    end

    // per-bank open/closed state and latched row
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bank_active <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (pre_all || ((pre_bank || close_rw) && (sdram_wire_ba == 2'(b)))) begin
                    bank_active[b] <= 1'b0;
                end else if (act_en && (sdram_wire_ba == 2'(b))) begin
                    bank_active[b] <= 1'b1;
                    bank_row[b]    <= sdram_wire_addr[ROW_BITS-1:0];
                end
            end
        end
    end

    // storage array, never cleared so data survives a reset
    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            if (!sdram_wire_dqm[0])
                mem[idx][7:0] <= sdram_wire_dq[7:0];
            if (!sdram_wire_dqm[1])
                mem[idx][15:8] <= sdram_wire_dq[15:8];
        end
    end

    // read return pipe; CL=3 enters one stage earlier than CL=2, frozen while cke=0
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            p1_valid  <= 1'b0;
            p0_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (sdram_wire_cke) begin
            out_valid <= p0_valid;
            out_data  <= p0_data;
            out_mask  <= p0_mask;
            p0_valid  <= p1_valid;
            p0_data   <= p1_data;
            p0_mask   <= p1_mask;
            p1_valid  <= 1'b0;
            if (rd_en) begin
                if (cl_3) begin
                    p1_valid <= 1'b1;
                    p1_data  <= rd_word;
                    p1_mask  <= sdram_wire_dqm;
                end else begin
                    p0_valid <= 1'b1;
                    p0_data  <= rd_word;
                    p0_mask  <= sdram_wire_dqm;
                end
            end
        end
    end

    // sticky capture of the first error
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            err      <= 1'b0;
            err_code <= 3'd0;
        end else if (!err && (err_now != 3'd0)) begin
            err      <= 1'b1;
            err_code <= err_now;
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a vector table for the main flow plus
// hand-written sequences for multi-cycle and reset corner cases.
module tb_sdram_responder;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] MRS = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] addr = '0;
    logic [1:0]  ba = '0;
    logic        cs_n = 1'b0;
    logic [2:0]  cmd_r = NOP;
    logic        cke = 1'b1;
    logic [1:0]  dqm = '0;
    logic [15:0] tb_dq = '0;
    logic        tb_drv_en = 1'b0;
    wire  [15:0] dq;
    logic        init_done;
    logic        err;
    logic [2:0]  err_code;

    int n_checks = 0;
    int n_pass   = 0;

    assign dq = tb_drv_en ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_responder dut (
        .clk_clk          (clk),
        .reset_reset      (rst),
        .sdram_wire_addr  (addr),
        .sdram_wire_ba    (ba),
        .sdram_wire_cs_n  (cs_n),
        .sdram_wire_ras_n (cmd_r[2]),
        .sdram_wire_cas_n (cmd_r[1]),
        .sdram_wire_we_n  (cmd_r[0]),
        .sdram_wire_cke   (cke),
        .sdram_wire_dqm   (dqm),
        .sdram_wire_dq    (dq),
        .init_done        (init_done),
        .err              (err),
        .err_code         (err_code)
    );

    typedef struct {
        string       name;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [1:0]  dqm;
        logic [15:0] wd;
        logic        drv;
        logic        done;
        logic        e;
        logic [2:0]  code;
        logic        chk;
        logic [15:0] exp_dq;
        logic [1:0]  zm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [2:0] c, logic [1:0] b, logic [12:0] a,
                                logic [1:0] m, logic [15:0] wd, logic drv,
                                logic dn, logic e, logic [2:0] code,
                                logic chk, logic [15:0] x, logic [1:0] zm);
        vec_t v;
        v.name = nm; v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.wd = wd; v.drv = drv;
        v.done = dn; v.e = e; v.code = code; v.chk = chk; v.exp_dq = x; v.zm = zm;
        return v;
    endfunction

    // one bus cycle; returns 2 time units after the sampling edge
    task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                        input logic [1:0] m, input logic [15:0] wd, input logic drv,
                        input logic ck);
        cmd_r = c; ba = b; addr = a; dqm = m; tb_dq = wd; tb_drv_en = drv; cke = ck;
        @(posedge clk);
        #1;
        tb_drv_en = 1'b0;
        cmd_r = NOP;
        #1;
    endtask

    task automatic nop();
        step(NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic chk_st(input string nm, input logic dn, input logic e, input logic [2:0] code);
        n_checks++;
        if ({init_done, err, err_code} === {dn, e, code})
            n_pass++;
        else
            $display("FAIL %s: init_done/err/err_code got %b/%b/%0d expected %b/%b/%0d",
                     nm, init_done, err, err_code, dn, e, code);
    endtask

    // a byte flagged in zm must be undriven (z, or 0 on a two-state simulator)
    task automatic chk_dq(input string nm, input logic [15:0] x, input logic [1:0] zm);
        logic        ok;
        logic [15:0] a;
        logic [7:0]  by;
        ok = 1'b1;
        a  = dq;
        for (int b = 0; b < 2; b++) begin
            by = a[8*b +: 8];
            if (zm[b])
                ok = ok && ((by === 8'hzz) || (by === 8'h00));
            else
                ok = ok && (by === x[8*b +: 8]);
        end
        n_checks++;
        if (ok)
            n_pass++;
        else
            $display("FAIL %s: dq got %h expected %h (undriven byte mask %b)", nm, a, x, zm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        nop();
        rst = 1'b0;
    endtask

    task automatic do_init(input logic [12:0] mrs_addr);
        step(PRE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0, 1'b1);
        step(REF, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 1'b1);
        step(REF, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 1'b1);
        step(MRS, 2'd0, mrs_addr, 2'b00, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        vec_t v;

        vecs.push_back(mk("pre_all",        PRE, 0, 13'h400, 2'b00, 16'h0,    0, 0, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("ref1",           REF, 0, 13'h000, 2'b00, 16'h0,    0, 0, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("ref2",           REF, 0, 13'h000, 2'b00, 16'h0,    0, 0, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("mrs_cl2",        MRS, 0, 13'h020, 2'b00, 16'h0,    0, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("act_b0_r5",      ACT, 0, 13'h005, 2'b00, 16'h0,    0, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("wr_beef",        WR,  0, 13'h003, 2'b00, 16'hBEEF, 1, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("rd_beef_c1",     RD,  0, 13'h003, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("rd_beef_c2",     NOP, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'hBEEF, 2'b00));
        vecs.push_back(mk("rd_beef_after",  NOP, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("pre_b0",         PRE, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("mrs_cl3",        MRS, 0, 13'h030, 2'b00, 16'h0,    0, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("act_b0_again",   ACT, 0, 13'h005, 2'b00, 16'h0,    0, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("wr_mask_hi",     WR,  0, 13'h003, 2'b10, 16'h1234, 1, 1, 0, 0, 0, 16'h0,    2'b00));
        vecs.push_back(mk("rd_cl3_c1",      RD,  0, 13'h003, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("rd_cl3_c2",      NOP, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("rd_cl3_c3",      NOP, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'hBE34, 2'b00));
        vecs.push_back(mk("rd_mask_lo_c1",  RD,  0, 13'h003, 2'b01, 16'h0,    0, 1, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("rd_mask_lo_c2",  NOP, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'h0,    2'b11));
        vecs.push_back(mk("rd_mask_lo_c3",  NOP, 0, 13'h000, 2'b00, 16'h0,    0, 1, 0, 0, 1, 16'hBE00, 2'b01));
        vecs.push_back(mk("rd_idle_b1",     RD,  1, 13'h003, 2'b00, 16'h0,    0, 1, 1, 4, 1, 16'h0,    2'b11));
        vecs.push_back(mk("act_dup_sticky1",ACT, 0, 13'h005, 2'b00, 16'h0,    0, 1, 1, 4, 0, 16'h0,    2'b00));
        vecs.push_back(mk("act_dup_sticky2",ACT, 0, 13'h005, 2'b00, 16'h0,    0, 1, 1, 4, 0, 16'h0,    2'b00));

        // reset state
        do_reset();
        chk_st("reset_state", 1'b0, 1'b0, 3'd0);
        chk_dq("reset_dq", 16'h0, 2'b11);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.cmd, v.ba, v.addr, v.dqm, v.wd, v.drv, 1'b1);
            chk_st(v.name, v.done, v.e, v.code);
            if (v.chk)
                chk_dq(v.name, v.exp_dq, v.zm);
        end

        // back-to-back reads at CL=2, then a write with auto-precharge
        do_reset();
        do_init(13'h020);
        chk_st("b2b_init", 1'b1, 1'b0, 3'd0);
        step(ACT, 2'd2, 13'h001, 2'b00, 16'h0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++)
            step(WR, 2'd2, 13'(c), 2'b00, 16'(16'h1111 * (c + 1)), 1'b1, 1'b1);
        step(RD, 2'd2, 13'h000, 2'b00, 16'h0, 1'b0, 1'b1);
        for (int c = 1; c < 5; c++) begin
            if (c < 4)
                step(RD, 2'd2, 13'(c), 2'b00, 16'h0, 1'b0, 1'b1);
            else
                nop();
            chk_dq($sformatf("b2b_word%0d", c - 1), 16'(16'h1111 * c), 2'b00);
        end
        nop();
        chk_dq("b2b_drained", 16'h0, 2'b11);
        step(WR, 2'd2, 13'h400, 2'b00, 16'h7777, 1'b1, 1'b1);
        chk_st("wr_autopre", 1'b1, 1'b0, 3'd0);
        step(RD, 2'd2, 13'h000, 2'b00, 16'h0, 1'b0, 1'b1);
        chk_st("rd_after_autopre", 1'b1, 1'b1, 3'd4);

        // write while a read is in flight: flagged but still performed
        do_reset();
        do_init(13'h020);
        step(ACT, 2'd0, 13'h005, 2'b00, 16'h0, 1'b0, 1'b1);
        step(RD,  2'd0, 13'h003, 2'b00, 16'h0, 1'b0, 1'b1);
        step(WR,  2'd0, 13'h005, 2'b00, 16'hA5A5, 1'b1, 1'b1);
        chk_st("bus_conflict", 1'b1, 1'b1, 3'd5);
        nop();
        nop();
        step(RD, 2'd0, 13'h005, 2'b00, 16'h0, 1'b0, 1'b1);
        nop();
        chk_dq("conflict_write_kept", 16'hA5A5, 2'b00);

        // command before init; init still completes, first error kept
        do_reset();
        step(ACT, 2'd0, 13'h005, 2'b00, 16'h0, 1'b0, 1'b1);
        chk_st("act_before_init", 1'b0, 1'b1, 3'd1);
        do_init(13'h020);
        chk_st("init_after_err", 1'b1, 1'b1, 3'd1);

        // refresh with an open bank
        do_reset();
        do_init(13'h020);
        step(ACT, 2'd3, 13'h002, 2'b00, 16'h0, 1'b0, 1'b1);
        step(REF, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 1'b1);
        chk_st("ref_bank_active", 1'b1, 1'b1, 3'd6);

        // reset during an in-flight read, then data survives re-init
        do_reset();
        do_init(13'h020);
        step(ACT, 2'd0, 13'h005, 2'b00, 16'h0, 1'b0, 1'b1);
        step(RD,  2'd0, 13'h003, 2'b00, 16'h0, 1'b0, 1'b1);
        rst = 1'b1;
        nop();
        chk_dq("reset_mid_read_dq", 16'h0, 2'b11);
        chk_st("reset_mid_read_st", 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        do_init(13'h020);
        step(ACT, 2'd0, 13'h005, 2'b00, 16'h0, 1'b0, 1'b1);
        step(RD,  2'd0, 13'h003, 2'b00, 16'h0, 1'b0, 1'b1);
        nop();
        chk_dq("data_after_reinit", 16'hBE34, 2'b00);

        // cke low freezes the read pipe and ignores commands
        step(RD,  2'd0, 13'h003, 2'b00, 16'h0, 1'b0, 1'b1);
        step(ACT, 2'd0, 13'h005, 2'b00, 16'h0, 1'b0, 1'b0);
        chk_dq("cke_hold1", 16'h0, 2'b11);
        chk_st("cke_cmd_ignored", 1'b1, 1'b0, 3'd0);
        step(NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 1'b0);
        chk_dq("cke_hold2", 16'h0, 2'b11);
        nop();
        chk_dq("cke_released", 16'hBE34, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
